data_memory_param: RTL and testbench
====================================

DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 8, address bus width.
REQ-003 Parameter DEPTH, default 2**ADDR_WIDTH, number of implemented words; 2 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 write_enable  input  1  write request this cycle.
REQ-007 read_enable  input  1  read request this cycle.
REQ-008 address  input  ADDR_WIDTH  word address shared by read and write.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 clear  input  1  request to zero the whole array.
REQ-011 data_out  output  DATA_WIDTH  registered read data.
REQ-012 read_valid  output  1  data_out updated by an accepted read at the previous edge.
REQ-013 ready  output  1  memory accepts read/write/clear requests.
REQ-014 addr_error  output  1  previous accepted request had address >= DEPTH.

Function
REQ-015 FSM states CLEAR and READY; ready SHALL be 1 exactly when state is READY.
REQ-016 In CLEAR, an internal counter SHALL write zero to mem[counter] each cycle, incrementing from 0; after writing DEPTH-1 the next state SHALL be READY, so CLEAR lasts exactly DEPTH cycles.
REQ-017 In READY, clear=1 at an edge SHALL enter CLEAR with counter 0; clear in CLEAR SHALL be ignored (no restart).
REQ-018 A request is accepted only at an edge where ready=1 and clear=0; write_enable, read_enable and clear when not accepted SHALL have no effect and produce no read_valid or addr_error.
REQ-019 clear and write_enable at the same edge in READY: clear wins, write dropped.
REQ-020 Accepted write with address < DEPTH SHALL store data_in in mem[address] at that edge.
REQ-021 Accepted read with address < DEPTH SHALL load mem[address] into data_out at that edge; read_valid=1 for the following cycle only.
REQ-022 Read and write to the same in-range address at the same edge SHALL be write-first: data_out = data_in.
REQ-023 data_out SHALL hold its value when no read is accepted.
REQ-024 Accepted request with address >= DEPTH: write dropped, read loads data_out = 0 with read_valid=1, addr_error=1 for the following cycle only.
REQ-025 addr_error and read_valid SHALL be single-cycle pulses, 0 otherwise.
REQ-026 Read latency SHALL be exactly one cycle; throughput one request per cycle, back-to-back allowed.

Reset
REQ-027 rst_n=0 SHALL immediately force state CLEAR, counter 0, ready 0, read_valid 0, addr_error 0, data_out 0.
REQ-028 Array contents are not reset asynchronously; they are zeroed by the CLEAR sequence starting at the first rising edge with rst_n=1.
REQ-029 rst_n asserted mid-CLEAR SHALL restart the sequence from counter 0 after release, taking a full DEPTH cycles.

Verification (bench instance DATA_WIDTH=8, ADDR_WIDTH=8, DEPTH=200)
REQ-030 Release rst_n -> ready=0 for 200 edges then 1; read address 15 -> data_out 8'h00, read_valid 1 next cycle.
REQ-031 Write 8'hF0 @15, then 8'h0F @100, then read 15, read 100 back-to-back -> data_out 8'hF0 then 8'h0F, read_valid high both cycles.
REQ-032 Write 8'hAA @15 with read_enable=1 same edge -> data_out 8'hAA next cycle; later read 15 -> 8'hAA.
REQ-033 Write 8'h55 @200 -> addr_error 1 for one cycle; read 200 -> data_out 8'h00, read_valid 1, addr_error 1; read 100 still 8'h0F.
REQ-034 Pulse clear with simultaneous write 8'h77 @15 -> ready 0 for 200 cycles, write during CLEAR ignored; then read 15 and 100 -> 8'h00.
REQ-035 Assert rst_n=0 when counter=50 of a CLEAR -> outputs reset at once; after release ready stays 0 for a full 200 cycles.

Source files
------------

// File: rtl/data_memory_param.sv
// Parameterised single-port data memory with a self-clearing sequence.
// The array is zeroed one word per cycle after reset or a clear request; requests are accepted only while ready.
module data_memory_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  ready,
  output logic                  addr_error
);

  localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH-1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        counter_reg, counter_next;
  logic [DATA_WIDTH-1:0]   data_out_reg;
  logic                    read_valid_reg;
  logic                    addr_error_reg;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  logic                    accept;
  logic                    in_range;
  logic [IDX_W-1:0]        addr_idx;
  logic                    mem_we;
  logic [IDX_W-1:0]        mem_wa;
  logic [DATA_WIDTH-1:0]   mem_wd;

  assign in_range = ({1'b0, address} < DEPTH_W);
  assign addr_idx = address[IDX_W-1:0];
  assign accept   = ready && !clear;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  // Next-state logic; clear is only honoured while READY
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    case (state_reg)
      CLEAR: begin
        if (counter_reg == LAST_IDX) begin
          state_next   = READY;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + 1'b1;
        end
      end
      READY: begin
        if (clear) begin
          state_next   = CLEAR;
          counter_next = '0;
        end
      end
      default: begin
        state_next   = CLEAR;
        counter_next = '0;
      end
    endcase
  end

  // Output and write-port selection: the clear sweep owns the single write port while busy
  always_comb begin
    ready  = (state_reg == READY);
    mem_we = 1'b0;
    mem_wa = counter_reg;
    mem_wd = '0;
    if (state_reg == CLEAR) begin
      mem_we = 1'b1;
    end else if (accept && write_enable && in_range) begin
      mem_we = 1'b1;
      mem_wa = addr_idx;
      mem_wd = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // Registered read, write-first on a same-address collision; out-of-range reads return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_reg   <= '0;
      read_valid_reg <= 1'b0;
      addr_error_reg <= 1'b0;
    end else begin
      read_valid_reg <= accept && read_enable;
      addr_error_reg <= accept && (read_enable || write_enable) && !in_range;
      if (accept && read_enable) begin
        if (!in_range) begin
          data_out_reg <= '0;
        end else if (write_enable) begin
          data_out_reg <= data_in;
        end else begin
          data_out_reg <= mem[addr_idx];
        end
      end
    end
  end

  assign data_out   = data_out_reg;
  assign read_valid = read_valid_reg;
  assign addr_error = addr_error_reg;

endmodule

// File: tb/tb_data_memory_param.sv
// Self-checking bench for data_memory_param (DATA_WIDTH=8, ADDR_WIDTH=8, DEPTH=200):
// directed vector table, clear/reset corner sequences, and a randomized run against a reference model.
module tb_data_memory_param;

  localparam int DEPTH = 200;

  logic       clk;
  logic       rst_n;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] address;
  logic [7:0] data_in;
  logic       clear;
  logic [7:0] data_out;
  logic       read_valid;
  logic       ready;
  logic       addr_error;

  int checks = 0;
  int errors = 0;

  data_memory_param #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .address     (address),
    .data_in     (data_in),
    .clear       (clear),
    .data_out    (data_out),
    .read_valid  (read_valid),
    .ready       (ready),
    .addr_error  (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       we;
    logic       re;
    logic       clr;
    logic [7:0] addr;
    logic [7:0] din;
    logic       exp_rv;
    logic       exp_ae;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs [16];

  logic [7:0] m_mem [0:DEPTH-1];
  logic [7:0] m_dout;
  int         m_busy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    clear        = 1'b0;
  endtask

  // Counts edges until ready rises, bounded so a stuck DUT cannot hang the run
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 400) begin
      step();
      n++;
    end
  endtask

  function automatic vec_t mk(string nm, logic we, logic re, logic [7:0] a, logic [7:0] d,
                              logic rv, logic ae, logic [7:0] dout);
    vec_t v;
    v.name = nm; v.we = we; v.re = re; v.clr = 1'b0; v.addr = a; v.din = d;
    v.exp_rv = rv; v.exp_ae = ae; v.exp_dout = dout;
    return v;
  endfunction

  initial begin
    int n;
    int bad;

    vecs[0]  = mk("rd15_init",   0, 1,  15, 8'h00, 1, 0, 8'h00);
    vecs[1]  = mk("wr15_F0",     1, 0,  15, 8'hF0, 0, 0, 8'h00);
    vecs[2]  = mk("wr100_0F",    1, 0, 100, 8'h0F, 0, 0, 8'h00);
    vecs[3]  = mk("rd15",        0, 1,  15, 8'h00, 1, 0, 8'hF0);
    vecs[4]  = mk("rd100",       0, 1, 100, 8'h00, 1, 0, 8'h0F);
    vecs[5]  = mk("wr_rd15_AA",  1, 1,  15, 8'hAA, 1, 0, 8'hAA);
    vecs[6]  = mk("idle_hold",   0, 0,  15, 8'h00, 0, 0, 8'hAA);
    vecs[7]  = mk("rd15_AA",     0, 1,  15, 8'h00, 1, 0, 8'hAA);
    vecs[8]  = mk("wr200_oor",   1, 0, 200, 8'h55, 0, 1, 8'hAA);
    vecs[9]  = mk("rd200_oor",   0, 1, 200, 8'h00, 1, 1, 8'h00);
    vecs[10] = mk("rd100_again", 0, 1, 100, 8'h00, 1, 0, 8'h0F);
    vecs[11] = mk("wr_rd255",    1, 1, 255, 8'h99, 1, 1, 8'h00);
    vecs[12] = mk("idle2",       0, 0,   0, 8'h00, 0, 0, 8'h00);
    vecs[13] = mk("rd199",       0, 1, 199, 8'h00, 1, 0, 8'h00);
    vecs[14] = mk("wr199_5A",    1, 0, 199, 8'h5A, 0, 0, 8'h00);
    vecs[15] = mk("rd199_5A",    0, 1, 199, 8'h00, 1, 0, 8'h5A);

    rst_n = 1'b0; address = '0; data_in = '0;
    idle();
    step(); step();
    chk("rst_ready", ready, 0);
    chk("rst_rv", read_valid, 0);
    chk("rst_ae", addr_error, 0);
    chk("rst_dout", data_out, 0);

    rst_n = 1'b1;
    wait_ready(n);
    chk("init_clear_len", n, DEPTH);
    $display("init clear: ready after %0d edges", n);

    foreach (vecs[i]) begin
      write_enable = vecs[i].we;
      read_enable  = vecs[i].re;
      clear        = vecs[i].clr;
      address      = vecs[i].addr;
      data_in      = vecs[i].din;
      step();
      $display("vec %s: we=%0b re=%0b a=%0d din=%h -> dout=%h rv=%0b ae=%0b rdy=%0b",
               vecs[i].name, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].din,
               data_out, read_valid, addr_error, ready);
      chk({vecs[i].name, "_dout"}, data_out, vecs[i].exp_dout);
      chk({vecs[i].name, "_rv"}, read_valid, vecs[i].exp_rv);
      chk({vecs[i].name, "_ae"}, addr_error, vecs[i].exp_ae);
      chk({vecs[i].name, "_ready"}, ready, 1);
    end

    // Clear with a simultaneous write; further requests during the sweep must be ignored
    clear = 1'b1; write_enable = 1'b1; read_enable = 1'b0; address = 15; data_in = 8'h77;
    step();
    chk("clr_ready", ready, 0);
    chk("clr_rv", read_valid, 0);
    chk("clr_ae", addr_error, 0);
    n = 1;
    bad = 0;
    while (!ready && n < 400) begin
      write_enable = 1'b1; read_enable = 1'b1; clear = 1'b1;
      address = (n % 2 == 0) ? 8'd15 : 8'd220; data_in = 8'h77;
      step();
      if (read_valid || addr_error || data_out != 8'h5A) bad++;
      n++;
    end
    $display("clear sweep: ready low for %0d cycles, %0d outputs disturbed", n, bad);
    chk("clr_len", n, DEPTH + 1);
    chk("clr_ignored", bad, 0);
    idle();
    read_enable = 1'b1;
    foreach (vecs[i]) begin
      if (i < 3) begin
        address = (i == 0) ? 8'd15 : (i == 1) ? 8'd100 : 8'd199;
        step();
        $display("post-clear rd %0d -> dout=%h rv=%0b", address, data_out, read_valid);
        chk("postclr_dout", data_out, 0);
        chk("postclr_rv", read_valid, 1);
      end
    end
    idle();

    // Randomized traffic checked against a plain array model
    foreach (m_mem[j]) m_mem[j] = 8'h00;
    m_dout = 8'h00;
    m_busy = 0;
    for (int i = 0; i < 800; i++) begin
      logic exp_rv, exp_ae;
      write_enable = 1'($urandom_range(0, 1));
      read_enable  = 1'($urandom_range(0, 1));
      clear        = ($urandom_range(0, 299) == 0);
      address      = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(200, 255))
                                                 : 8'($urandom_range(0, 199));
      data_in      = 8'($urandom);
      exp_rv = 1'b0;
      exp_ae = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
      end else if (clear) begin
        m_busy = DEPTH;
        foreach (m_mem[j]) m_mem[j] = 8'h00;
      end else begin
        if ((write_enable || read_enable) && address >= DEPTH) exp_ae = 1'b1;
        if (read_enable) begin
          exp_rv = 1'b1;
          if (address >= DEPTH)  m_dout = 8'h00;
          else if (write_enable) m_dout = data_in;
          else                   m_dout = m_mem[address];
        end
        if (write_enable && address < DEPTH) m_mem[address] = data_in;
      end
      step();
      if (i % 50 == 0)
        $display("rand %0d: we=%0b re=%0b clr=%0b a=%0d -> dout=%h rv=%0b ae=%0b rdy=%0b",
                 i, write_enable, read_enable, clear, address, data_out, read_valid,
                 addr_error, ready);
      chk("rand_ready", ready, (m_busy == 0) ? 1 : 0);
      chk("rand_rv", read_valid, exp_rv);
      chk("rand_ae", addr_error, exp_ae);
      chk("rand_dout", data_out, m_dout);
    end
    idle();
    wait_ready(n);
    chk("rand_settle", ready, 1);

    // Reset in the middle of a clear sweep (counter at 50)
    write_enable = 1'b1; address = 5; data_in = 8'h3C;
    step();
    write_enable = 1'b0; read_enable = 1'b1;
    step();
    chk("pre_rst_dout", data_out, 8'h3C);
    idle();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (50) step();
    chk("midclr_busy", ready, 0);
    rst_n = 1'b0;
    #1;
    $display("async reset mid-clear: dout=%h rv=%0b ae=%0b rdy=%0b",
             data_out, read_valid, addr_error, ready);
    chk("async_dout", data_out, 0);
    chk("async_rv", read_valid, 0);
    chk("async_ae", addr_error, 0);
    chk("async_ready", ready, 0);
    step(); step();
    rst_n = 1'b1;
    wait_ready(n);
    $display("restart clear: ready after %0d edges", n);
    chk("restart_len", n, DEPTH);
    read_enable = 1'b1; address = 5;
    step();
    chk("restart_rd5", data_out, 0);
    chk("restart_rv", read_valid, 1);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
